// File: rtl/ex_iter_stage.sv
// Execute stage: single-cycle ALU plus iterative multiply/divide.
// Results register into the EX/MEM boundary; multi-cycle ops stall upstream.
module ex_iter_stage #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5,
    parameter int CNT_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       in_aluop,
    input  logic [XLEN-1:0]  in_op1,
    input  logic [XLEN-1:0]  in_op2,
    input  logic [4:0]       in_rd,
    input  logic             in_regwrite,
    input  logic             flush,
    output logic             stall,
    output logic             out_valid,
    output logic [XLEN-1:0]  out_result,
    output logic             out_zero,
    output logic [4:0]       out_rd,
    output logic             out_regwrite
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MUL_RUN = 2'd1;
    localparam logic [1:0] DIV_RUN = 2'd2;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_LT    = 4'd5;
    localparam logic [3:0] OP_LTU   = 4'd6;
    localparam logic [3:0] OP_SLL   = 4'd7;
    localparam logic [3:0] OP_SRL   = 4'd8;
    localparam logic [3:0] OP_NOPE  = 4'd9;
    localparam logic [3:0] OP_SRA   = 4'd10;
    localparam logic [3:0] OP_MUL   = 4'd11;
    localparam logic [3:0] OP_MULHU = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [3:0]         op_q;
    logic [4:0]         rd_q;
    logic               rw_q;
    logic [XLEN:0]      acc_hi;
    logic [XLEN-1:0]    acc_lo;
    logic [XLEN-1:0]    divisor;

    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    alu_res;
    logic               is_multi;
    logic               cnt_last;
    logic [XLEN:0]      mul_sum;
    logic [XLEN:0]      div_sh;
    logic               div_ge;
    logic [XLEN:0]      step_hi;
    logic [XLEN-1:0]    step_lo;
    logic [XLEN-1:0]    iter_res;

    assign shamt    = in_op2[SHAMT_W-1:0];
    assign is_multi = (in_aluop >= OP_MUL) && (in_aluop <= 4'd14);
    assign cnt_last = (cnt == CNT_W'(1));

    assign stall = !rst && !flush &&
                   (((state == IDLE) && in_valid && is_multi) ||
                    ((state != IDLE) && !cnt_last));

    always_comb begin
        alu_res = '0;
        unique case (in_aluop)
            OP_ADD:  alu_res = in_op1 + in_op2;
            OP_SUB:  alu_res = in_op1 - in_op2;
            OP_AND:  alu_res = in_op1 & in_op2;
            OP_OR:   alu_res = in_op1 | in_op2;
            OP_XOR:  alu_res = in_op1 ^ in_op2;
            OP_LT:   alu_res = {{(XLEN-1){1'b0}}, $signed(in_op1) < $signed(in_op2)};
            OP_LTU:  alu_res = {{(XLEN-1){1'b0}}, in_op1 < in_op2};
            OP_SLL:  alu_res = in_op1 << shamt;
            OP_SRL:  alu_res = in_op1 >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(in_op1) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    // Multiply: shift-add on {hi,lo}. Divide: restoring, quotient shifts into lo.
    always_comb begin
        mul_sum = {1'b0, acc_hi[XLEN-1:0]} + (acc_lo[0] ? {1'b0, divisor} : '0);
        div_sh  = {acc_hi[XLEN-1:0], acc_lo[XLEN-1]};
        div_ge  = (div_sh >= {1'b0, divisor});
        step_hi = acc_hi;
        step_lo = acc_lo;
        if (state == MUL_RUN) begin
            step_hi = {1'b0, mul_sum[XLEN:1]};
            step_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
        end else if (state == DIV_RUN) begin
            step_hi = div_ge ? div_sh - {1'b0, divisor} : div_sh;
            step_lo = {acc_lo[XLEN-2:0], div_ge};
        end
    end

    always_comb begin
        iter_res = '0;
        unique case (op_q)
            OP_MUL:   iter_res = step_lo;
            OP_MULHU: iter_res = step_hi[XLEN-1:0];
            OP_DIVU:  iter_res = step_lo;
            default:  iter_res = step_hi[XLEN-1:0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            op_q         <= '0;
            rd_q         <= '0;
            rw_q         <= 1'b0;
            acc_hi       <= '0;
            acc_lo       <= '0;
            divisor      <= '0;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_zero     <= 1'b0;
            out_rd       <= '0;
            out_regwrite <= 1'b0;
        end else if (flush) begin
            state        <= IDLE;
            cnt          <= '0;
            out_valid    <= 1'b0;
            out_regwrite <= 1'b0;
        end else if (state == IDLE) begin
            out_valid    <= 1'b0;
            out_regwrite <= 1'b0;
            if (in_valid && is_multi) begin
                state   <= (in_aluop <= OP_MULHU) ? MUL_RUN : DIV_RUN;
                cnt     <= CNT_W'(XLEN);
                op_q    <= in_aluop;
                rd_q    <= in_rd;
                rw_q    <= in_regwrite;
                acc_hi  <= '0;
                acc_lo  <= in_op1;
                divisor <= in_op2;
            end else if (in_valid) begin
                out_valid    <= 1'b1;
                out_result   <= alu_res;
                out_zero     <= (in_aluop != OP_NOPE) && (alu_res == '0);
                out_rd       <= in_rd;
                out_regwrite <= in_regwrite;
            end
        end else begin
            acc_hi       <= step_hi;
            acc_lo       <= step_lo;
            cnt          <= cnt - CNT_W'(1);
            out_valid    <= 1'b0;
            out_regwrite <= 1'b0;
            if (cnt_last) begin
                state        <= IDLE;
                out_valid    <= 1'b1;
                out_result   <= iter_res;
                out_zero     <= (iter_res == '0);
                out_rd       <= rd_q;
                out_regwrite <= rw_q;
            end
        end
    end

endmodule

// File: tb/tb_ex_iter_stage.sv
// Bench for ex_iter_stage: directed and random ops against an arithmetic model.
// Second instance exercises XLEN=16.
module tb_ex_iter_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  in_aluop;
    logic [31:0] in_op1;
    logic [31:0] in_op2;
    logic [4:0]  in_rd;
    logic        in_regwrite;
    logic        flush;
    logic        stall;
    logic        out_valid;
    logic [31:0] out_result;
    logic        out_zero;
    logic [4:0]  out_rd;
    logic        out_regwrite;

    logic        h_in_valid;
    logic [3:0]  h_in_aluop;
    logic [15:0] h_in_op1;
    logic [15:0] h_in_op2;
    logic [4:0]  h_in_rd;
    logic        h_in_regwrite;
    logic        h_flush;
    logic        h_stall;
    logic        h_out_valid;
    logic [15:0] h_out_result;
    logic        h_out_zero;
    logic [4:0]  h_out_rd;
    logic        h_out_regwrite;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ex_iter_stage #(.XLEN(32), .SHAMT_W(5), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_aluop(in_aluop),
        .in_op1(in_op1), .in_op2(in_op2), .in_rd(in_rd),
        .in_regwrite(in_regwrite), .flush(flush), .stall(stall),
        .out_valid(out_valid), .out_result(out_result), .out_zero(out_zero),
        .out_rd(out_rd), .out_regwrite(out_regwrite)
    );

    ex_iter_stage #(.XLEN(16), .SHAMT_W(4), .CNT_W(5)) dut16 (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_aluop(h_in_aluop),
        .in_op1(h_in_op1), .in_op2(h_in_op2), .in_rd(h_in_rd),
        .in_regwrite(h_in_regwrite), .flush(h_flush), .stall(h_stall),
        .out_valid(h_out_valid), .out_result(h_out_result),
        .out_zero(h_out_zero), .out_rd(h_out_rd),
        .out_regwrite(h_out_regwrite)
    );

    function automatic logic [31:0] model(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint unsigned pa, pb, p;
        int sa;
        pa = a;
        pb = b;
        p  = pa * pb;
        sa = a;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:  return (a < b) ? 32'd1 : 32'd0;
            4'd7:  return a << b[4:0];
            4'd8:  return a >> b[4:0];
            4'd10: return sa >>> b[4:0];
            4'd11: return p[31:0];
            4'd12: return p[63:32];
            4'd13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd14: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int exp_edges(input logic [3:0] op);
        return (op >= 4'd11 && op <= 4'd14) ? 33 : 1;
    endfunction

    // Presents one instruction and holds it until stall is low at an edge.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic rw, output int edges, output int stalls);
        logic lst;
        in_valid    = 1'b1;
        in_aluop    = op;
        in_op1      = a;
        in_op2      = b;
        in_rd       = rd;
        in_regwrite = rw;
        edges  = 0;
        stalls = 0;
        #1;
        while (edges < 100) begin
            lst = stall;
            if (lst) stalls++;
            @(posedge clk);
            #1;
            edges++;
            if (!lst) break;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2;
        n_cmp++;
        if ({out_valid, out_result, out_zero, out_rd, out_regwrite, stall} !== '0) begin
            n_err++;
            $display("FAIL reset: outputs=%h required 0",
                     {out_valid, out_result, out_zero, out_rd, out_regwrite, stall});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string nm, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_r, input logic exp_z);
        int e, s;
        run_op(op, a, b, 5'd3, 1'b1, e, s);
        n_cmp++;
        if (out_valid !== 1'b1 || out_result !== exp_r || out_zero !== exp_z ||
            out_rd !== 5'd3 || out_regwrite !== 1'b1) begin
            n_err++;
            $display("FAIL %s: v=%b r=%h z=%b rd=%0d rw=%b required v=1 r=%h z=%b rd=3 rw=1",
                     nm, out_valid, out_result, out_zero, out_rd, out_regwrite, exp_r, exp_z);
        end
        n_cmp++;
        if (e !== exp_edges(op) || s !== exp_edges(op) - 1) begin
            n_err++;
            $display("FAIL %s_timing: edges=%0d stalls=%0d required %0d/%0d",
                     nm, e, s, exp_edges(op), exp_edges(op) - 1);
        end
    endtask

    task automatic test_alu;
        logic [31:0] keep;
        directed("add", 4'd0, 32'd5, 32'd7, 32'd12, 1'b0);
        directed("sub_zero", 4'd1, 32'd7, 32'd7, 32'd0, 1'b1);
        directed("lt", 4'd5, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        directed("ltu", 4'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
        directed("sra", 4'd10, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
        directed("nope", 4'd9, 32'd3, 32'd4, 32'd0, 1'b0);
        directed("op15", 4'd15, 32'd3, 32'd4, 32'd0, 1'b1);
        keep = out_result;
        directed("sll", 4'd7, 32'h0000_0003, 32'h0000_0021, 32'h0000_0006, 1'b0);
        keep = out_result;
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_regwrite !== 1'b0 || out_result !== keep) begin
            n_err++;
            $display("FAIL idle_hold: v=%b rw=%b r=%h required v=0 rw=0 r=%h",
                     out_valid, out_regwrite, out_result, keep);
        end
    endtask

    task automatic test_mul_div;
        directed("mul", 4'd11, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 1'b0);
        directed("mulhu", 4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        directed("divu", 4'd13, 32'd100, 32'd7, 32'd14, 1'b0);
        directed("remu", 4'd14, 32'd100, 32'd7, 32'd2, 1'b0);
        directed("divu_z", 4'd13, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
        directed("remu_z", 4'd14, 32'd5, 32'd0, 32'd5, 1'b0);
    endtask

    task automatic test_random;
        logic [3:0]  op;
        logic [31:0] a, b, r;
        logic [4:0]  rd;
        logic        rw;
        int e, s;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            rd = 5'($urandom);
            rw = 1'($urandom);
            r  = model(op, a, b);
            run_op(op, a, b, rd, rw, e, s);
            n_cmp++;
            if (out_valid !== 1'b1 || out_result !== r || out_rd !== rd ||
                out_regwrite !== rw || out_zero !== (op != 4'd9 && r == 0) ||
                e !== exp_edges(op)) begin
                n_err++;
                $display("FAIL rand op=%0d a=%h b=%h: v=%b r=%h rd=%0d rw=%b z=%b e=%0d required r=%h rd=%0d rw=%b e=%0d",
                         op, a, b, out_valid, out_result, out_rd, out_regwrite,
                         out_zero, e, r, rd, rw, exp_edges(op));
            end
        end
    endtask

    task automatic test_back_to_back;
        int e, s;
        run_op(4'd11, 32'd6, 32'd7, 5'd9, 1'b1, e, s);
        n_cmp++;
        if (out_valid !== 1'b1 || out_result !== 32'd42 || out_rd !== 5'd9) begin
            n_err++;
            $display("FAIL b2b_mul: v=%b r=%h rd=%0d required v=1 r=2a rd=9",
                     out_valid, out_result, out_rd);
        end
        run_op(4'd0, 32'd1, 32'd1, 5'd4, 1'b1, e, s);
        n_cmp++;
        if (out_valid !== 1'b1 || out_result !== 32'd2 || out_rd !== 5'd4 || e !== 1) begin
            n_err++;
            $display("FAIL b2b_add: v=%b r=%h rd=%0d e=%0d required v=1 r=2 rd=4 e=1",
                     out_valid, out_result, out_rd, e);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_dup: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_flush;
        int e, s, seen;
        in_valid = 1'b1; in_aluop = 4'd11; in_op1 = 32'd3; in_op2 = 32'd5;
        in_rd = 5'd7; in_regwrite = 1'b1;
        repeat (23) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL flush_stall: stall=%b required 0", stall);
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || out_regwrite !== 1'b0) begin
            n_err++;
            $display("FAIL flush_out: v=%b rw=%b required 0/0", out_valid, out_regwrite);
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid || stall) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL flush_quiet: active cycles=%0d required 0", seen);
        end
        directed("flush_add", 4'd0, 32'd20, 32'd22, 32'd42, 1'b0);
    endtask

    task automatic test_rst_mid;
        directed("pre_rst", 4'd3, 32'h0F, 32'hF0, 32'hFF, 1'b0);
        in_valid = 1'b1; in_aluop = 4'd13; in_op1 = 32'd99; in_op2 = 32'd9;
        in_rd = 5'd6; in_regwrite = 1'b1;
        repeat (28) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, out_result, out_zero, out_rd, out_regwrite, stall} !== '0) begin
            n_err++;
            $display("FAIL rst_mid: outputs=%h required 0",
                     {out_valid, out_result, out_zero, out_rd, out_regwrite, stall});
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        directed("post_rst", 4'd4, 32'hA5, 32'h0F, 32'hAA, 1'b0);
    endtask

    task automatic test_xlen16;
        int e, s;
        logic lst;
        h_in_valid = 1'b1; h_in_aluop = 4'd11; h_in_op1 = 16'h00FF;
        h_in_op2 = 16'h0101; h_in_rd = 5'd2; h_in_regwrite = 1'b1;
        e = 0;
        s = 0;
        #1;
        while (e < 100) begin
            lst = h_stall;
            if (lst) s++;
            @(posedge clk);
            #1;
            e++;
            if (!lst) break;
        end
        h_in_valid = 1'b0;
        n_cmp++;
        if (h_out_valid !== 1'b1 || h_out_result !== 16'hFFFF || e !== 17 || s !== 16) begin
            n_err++;
            $display("FAIL x16_mul: v=%b r=%h edges=%0d stalls=%0d required v=1 r=ffff edges=17 stalls=16",
                     h_out_valid, h_out_result, e, s);
        end
    endtask

    initial begin
        in_valid = 1'b0; in_aluop = '0; in_op1 = '0; in_op2 = '0;
        in_rd = '0; in_regwrite = 1'b0; flush = 1'b0;
        h_in_valid = 1'b0; h_in_aluop = '0; h_in_op1 = '0; h_in_op2 = '0;
        h_in_rd = '0; h_in_regwrite = 1'b0; h_flush = 1'b0;
        test_reset;
        test_alu;
        test_mul_div;
        test_random;
        test_back_to_back;
        test_flush;
        test_rst_mid;
        test_xlen16;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
